// File: rtl/s386_stim_driver.sv
// BIST stimulus driver for the s386 controller: LFSR pattern source, MISR response compactor, golden compare.
// Optional build macro STIM_ABORT_EN adds an abort input that ends a run early with pass forced low.
module s386_stim_driver #(
    parameter int unsigned NUM_PATTERNS = 256,
    parameter int unsigned FLUSH_CYC    = 8,
    parameter logic [6:0]  SEED         = 7'h01
) (
    input  logic        CK,
    input  logic        RESETN,
    input  logic        start,
    input  logic [15:0] golden,
    input  logic [6:0]  resp,
`ifdef STIM_ABORT_EN
    input  logic        abort,
`endif
    output logic [6:0]  pi,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] count
);

    localparam logic [6:0]  SEED_EFF   = (SEED == 7'h00) ? 7'h01 : SEED;
    localparam logic [15:0] NUM_P      = 16'(NUM_PATTERNS);
    localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [6:0] lfsr_step(input logic [6:0] q);
        lfsr_step = {q[5:0], q[6] ^ q[5]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] r);
        misr_step = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'b0_0000_0000, r};
    endfunction

    state_t      r_state;
    logic [6:0]  r_lfsr;
    logic [7:0]  r_flush_cnt;
    logic [6:0]  r_pi;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_sig;
    logic [15:0] r_count;
    logic [6:0]  r_resp_q;
    logic        r_valid_q;
    logic [15:0] w_sig_next;
    logic        w_abort;

    // Next MISR value from the registered response, and the abort qualifier.
    always_comb begin
        w_sig_next = misr_step(r_sig, r_resp_q);
`ifdef STIM_ABORT_EN
        w_abort = abort && ((r_state == S_FLUSH) || (r_state == S_RUN) || (r_state == S_DRAIN));
`else
        w_abort = 1'b0;
`endif
    end

    // Response capture: one-cycle register plus a delayed RUN flag marking valid responses.
    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            r_resp_q  <= 7'h00;
            r_valid_q <= 1'b0;
        end else begin
            r_resp_q  <= resp;
            r_valid_q <= (r_state == S_RUN);
        end
    end

    // Run sequencer with registered stimulus, status, count and signature.
    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED_EFF;
            r_flush_cnt <= 8'h00;
            r_pi        <= 7'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_sig       <= 16'h0000;
            r_count     <= 16'h0000;
        end else if (w_abort) begin
            // Signature and count are left frozen at their current values.
            r_state <= S_DONE;
            r_pi    <= 7'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pi   <= 7'h00;
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_FLUSH;
                        r_busy      <= 1'b1;
                        r_sig       <= 16'h0000;
                        r_count     <= 16'h0000;
                        r_pass      <= 1'b0;
                        r_lfsr      <= SEED_EFF;
                        r_flush_cnt <= 8'h00;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_state <= S_RUN;
                        r_pi    <= r_lfsr;
                        r_lfsr  <= lfsr_step(r_lfsr);
                        r_count <= r_count + 16'h0001;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 8'h01;
                    end
                end
                S_RUN: begin
                    if (r_valid_q) begin
                        r_sig <= w_sig_next;
                    end
                    if (r_count == NUM_P) begin
                        r_state <= S_DRAIN;
                        r_pi    <= 7'h00;
                    end else begin
                        r_pi    <= r_lfsr;
                        r_lfsr  <= lfsr_step(r_lfsr);
                        r_count <= r_count + 16'h0001;
                    end
                end
                S_DRAIN: begin
                    // The last RUN response is always pending here.
                    r_sig   <= w_sig_next;
                    r_pass  <= (w_sig_next == golden);
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pi    <= 7'h00;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pi        = r_pi;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_sig;
    assign count     = r_count;

endmodule

// File: tb/tb_s386_stim_driver.sv
// Self-checking bench for s386_stim_driver: table-driven runs plus directed reset, loopback and abort sequences.
module tb_s386_stim_driver;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic rst_n, rst_big;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        start_one, start_two, start_big, start_loop;
    logic [15:0] golden_one, golden_two, golden_big, golden_loop;
    logic [6:0]  resp_one, resp_two, resp_big, resp_loop;
    logic [6:0]  pi_one, pi_two, pi_big, pi_loop;
    logic        busy_one, busy_two, busy_big, busy_loop;
    logic        done_one, done_two, done_big, done_loop;
    logic        pass_one, pass_two, pass_big, pass_loop;
    logic [15:0] sig_one, sig_two, sig_big, sig_loop;
    logic [15:0] count_one, count_two, count_big, count_loop;
`ifdef STIM_ABORT_EN
    logic        abort_one, abort_two, abort_big, abort_loop;
`endif

    assign resp_big = pi_big ^ 7'h55;
    always @(posedge CK) resp_loop <= pi_loop;

    s386_stim_driver #(.NUM_PATTERNS(1), .FLUSH_CYC(1), .SEED(7'h01)) u_one (
        .CK(CK), .RESETN(rst_n), .start(start_one), .golden(golden_one), .resp(resp_one),
`ifdef STIM_ABORT_EN
        .abort(abort_one),
`endif
        .pi(pi_one), .busy(busy_one), .done(done_one), .pass(pass_one),
        .signature(sig_one), .count(count_one));

    s386_stim_driver #(.NUM_PATTERNS(2), .FLUSH_CYC(1), .SEED(7'h00)) u_two (
        .CK(CK), .RESETN(rst_n), .start(start_two), .golden(golden_two), .resp(resp_two),
`ifdef STIM_ABORT_EN
        .abort(abort_two),
`endif
        .pi(pi_two), .busy(busy_two), .done(done_two), .pass(pass_two),
        .signature(sig_two), .count(count_two));

    s386_stim_driver u_big (
        .CK(CK), .RESETN(rst_big), .start(start_big), .golden(golden_big), .resp(resp_big),
`ifdef STIM_ABORT_EN
        .abort(abort_big),
`endif
        .pi(pi_big), .busy(busy_big), .done(done_big), .pass(pass_big),
        .signature(sig_big), .count(count_big));

    s386_stim_driver #(.NUM_PATTERNS(127), .FLUSH_CYC(8), .SEED(7'h01)) u_loop (
        .CK(CK), .RESETN(rst_n), .start(start_loop), .golden(golden_loop), .resp(resp_loop),
`ifdef STIM_ABORT_EN
        .abort(abort_loop),
`endif
        .pi(pi_loop), .busy(busy_loop), .done(done_loop), .pass(pass_loop),
        .signature(sig_loop), .count(count_loop));

    typedef struct {
        logic [6:0]  resp;
        logic [15:0] golden;
        logic [15:0] exp_first;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [6:0] f_lfsr(input logic [6:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

    function automatic logic [15:0] f_misr(input logic [15:0] s, input logic [6:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {9'd0, r};
    endfunction

    // Signature of u_big after n_resp compacted responses (resp = pattern ^ 0x55).
    function automatic logic [15:0] big_model(input int n_resp);
        logic [15:0] s;
        logic [6:0]  p;
        s = 16'h0000;
        p = 7'h01;
        for (int i = 0; i < n_resp; i++) begin
            s = f_misr(s, p ^ 7'h55);
            p = f_lfsr(p);
        end
        return s;
    endfunction

    // Loopback run: first response is the flush zero, then patterns 1..126.
    function automatic logic [15:0] loop_model();
        logic [15:0] s;
        logic [6:0]  p;
        s = f_misr(16'h0000, 7'h00);
        p = 7'h01;
        for (int i = 0; i < 126; i++) begin
            s = f_misr(s, p);
            p = f_lfsr(p);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic run_two(input vec_t v, input int idx);
        resp_two   = v.resp;
        golden_two = v.golden;
        start_two  = 1'b1;
        tick();
        start_two = 1'b0;
        check($sformatf("two[%0d] flush busy", idx), 32'(busy_two), 32'd1);
        check($sformatf("two[%0d] flush pass clr", idx), 32'(pass_two), 32'd0);
        check($sformatf("two[%0d] flush sig clr", idx), 32'(sig_two), 32'd0);
        check($sformatf("two[%0d] flush pi", idx), 32'(pi_two), 32'd0);
        tick();
        check($sformatf("two[%0d] run1 pi", idx), 32'(pi_two), 32'h01);
        check($sformatf("two[%0d] run1 count", idx), 32'(count_two), 32'd1);
        tick();
        check($sformatf("two[%0d] run2 pi", idx), 32'(pi_two), 32'h02);
        check($sformatf("two[%0d] run2 count", idx), 32'(count_two), 32'd2);
        check($sformatf("two[%0d] run2 sig", idx), 32'(sig_two), 32'd0);
        tick();
        check($sformatf("two[%0d] drain pi", idx), 32'(pi_two), 32'd0);
        check($sformatf("two[%0d] drain busy", idx), 32'(busy_two), 32'd1);
        check($sformatf("two[%0d] first sig", idx), 32'(sig_two), 32'(v.exp_first));
        tick();
        check($sformatf("two[%0d] done", idx), 32'(done_two), 32'd1);
        check($sformatf("two[%0d] done busy", idx), 32'(busy_two), 32'd0);
        check($sformatf("two[%0d] sig", idx), 32'(sig_two), 32'(v.exp_sig));
        check($sformatf("two[%0d] pass", idx), 32'(pass_two), 32'(v.exp_pass));
        tick();
        check($sformatf("two[%0d] done pulse", idx), 32'(done_two), 32'd0);
        tick();
        tick();
        check($sformatf("two[%0d] pass hold", idx), 32'(pass_two), 32'(v.exp_pass));
        check($sformatf("two[%0d] sig hold", idx), 32'(sig_two), 32'(v.exp_sig));
    endtask

    task automatic run_big_full(input string tag);
        int n;
        int n_busy;
        golden_big = big_model(256);
        start_big  = 1'b1;
        tick();
        start_big = 1'b0;
        n      = 0;
        n_busy = busy_big ? 1 : 0;
        while (!done_big && n < 400) begin
            tick();
            n++;
            if (busy_big) n_busy++;
        end
        check({tag, " latency"}, 32'(n), 32'd265);
        check({tag, " busy cycles"}, 32'(n_busy), 32'd265);
        check({tag, " pass"}, 32'(pass_big), 32'd1);
        check({tag, " sig"}, 32'(sig_big), 32'(big_model(256)));
        check({tag, " count"}, 32'(count_big), 32'd256);
        tick();
    endtask

    initial begin
        int n;
        int distinct;
        logic [127:0] seen;

        vecs[0] = '{resp: 7'h7F, golden: 16'h0081, exp_first: 16'h007F, exp_sig: 16'h0081, exp_pass: 1'b1};
        vecs[1] = '{resp: 7'h7F, golden: 16'h0080, exp_first: 16'h007F, exp_sig: 16'h0081, exp_pass: 1'b0};
        vecs[2] = '{resp: 7'h00, golden: 16'h0000, exp_first: 16'h0000, exp_sig: 16'h0000, exp_pass: 1'b1};
        vecs[3] = '{resp: 7'h01, golden: 16'h0003, exp_first: 16'h0001, exp_sig: 16'h0003, exp_pass: 1'b1};
        vecs[4] = '{resp: 7'h40, golden: 16'h00C1, exp_first: 16'h0040, exp_sig: 16'h00C0, exp_pass: 1'b0};

        rst_n = 1'b0;
        rst_big = 1'b0;
        start_one = 1'b0; start_two = 1'b0; start_big = 1'b0; start_loop = 1'b0;
        golden_one = 16'h0000; golden_two = 16'h0000; golden_big = 16'h0000; golden_loop = 16'h0000;
        resp_one = 7'h00; resp_two = 7'h00;
`ifdef STIM_ABORT_EN
        abort_one = 1'b0; abort_two = 1'b0; abort_big = 1'b0; abort_loop = 1'b0;
`endif
        #2;
        check("reset pi", 32'(pi_big), 32'd0);
        check("reset busy", 32'(busy_big), 32'd0);
        check("reset done", 32'(done_big), 32'd0);
        check("reset pass", 32'(pass_two), 32'd0);
        check("reset sig", 32'(sig_two), 32'd0);
        check("reset count", 32'(count_two), 32'd0);
        @(negedge CK);
        @(negedge CK);
        rst_n = 1'b1;
        rst_big = 1'b1;
        tick();

        // Minimal run, then start held high to show retrigger from IDLE.
        start_one = 1'b1;
        tick();
        check("one flush busy", 32'(busy_one), 32'd1);
        tick();
        check("one run pi", 32'(pi_one), 32'h01);
        check("one run count", 32'(count_one), 32'd1);
        tick();
        check("one drain pi", 32'(pi_one), 32'd0);
        check("one drain busy", 32'(busy_one), 32'd1);
        tick();
        check("one done", 32'(done_one), 32'd1);
        check("one pass", 32'(pass_one), 32'd1);
        check("one sig", 32'(sig_one), 32'd0);
        check("one done busy", 32'(busy_one), 32'd0);
        tick();
        check("one idle busy", 32'(busy_one), 32'd0);
        check("one idle done", 32'(done_one), 32'd0);
        tick();
        check("one retrigger busy", 32'(busy_one), 32'd1);
        start_one = 1'b0;
        n = 0;
        while (!done_one && n < 10) begin
            tick();
            n++;
        end
        check("one rerun done", 32'(done_one), 32'd1);
        tick();

        for (int i = 0; i < 5; i++) run_two(vecs[i], i);

        // Reset mid-RUN, no done pulse, fresh start needed.
        start_big = 1'b1;
        tick();
        start_big = 1'b0;
        n = 0;
        while (count_big != 16'd10 && n < 50) begin
            tick();
            n++;
        end
        check("big reach count10", 32'(count_big), 32'd10);
        rst_big = 1'b0;
        #1;
        check("big rst pi", 32'(pi_big), 32'd0);
        check("big rst busy", 32'(busy_big), 32'd0);
        check("big rst count", 32'(count_big), 32'd0);
        check("big rst sig", 32'(sig_big), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("big rst no done", 32'(done_big), 32'd0);
        end
        rst_big = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("big idle after rst", 32'(busy_big | done_big), 32'd0);
        end
        run_big_full("big run");

`ifdef STIM_ABORT_EN
        start_big = 1'b1;
        tick();
        start_big = 1'b0;
        n = 0;
        while (count_big != 16'd5 && n < 50) begin
            tick();
            n++;
        end
        check("abort reach count5", 32'(count_big), 32'd5);
        abort_big = 1'b1;
        tick();
        abort_big = 1'b0;
        check("abort done", 32'(done_big), 32'd1);
        check("abort pass", 32'(pass_big), 32'd0);
        check("abort busy", 32'(busy_big), 32'd0);
        check("abort count", 32'(count_big), 32'd5);
        check("abort sig", 32'(sig_big), 32'(big_model(3)));
        check("abort pi", 32'(pi_big), 32'd0);
        tick();
        check("abort done pulse", 32'(done_big), 32'd0);
        tick();
        run_big_full("big after abort");
`endif

        // Loopback run over the full LFSR period with a stray start mid-run.
        golden_loop = loop_model();
        start_loop  = 1'b1;
        tick();
        start_loop = 1'b0;
        n = 0;
        distinct = 0;
        seen = '0;
        while (!done_loop && n < 300) begin
            tick();
            n++;
            start_loop = (n == 50);
            if (busy_loop && pi_loop != 7'h00) begin
                if (!seen[pi_loop]) distinct++;
                seen[pi_loop] = 1'b1;
            end
        end
        start_loop = 1'b0;
        check("loop latency", 32'(n), 32'd136);
        check("loop distinct pi", 32'(distinct), 32'd127);
        check("loop count", 32'(count_loop), 32'd127);
        check("loop sig", 32'(sig_loop), 32'(loop_model()));
        check("loop pass", 32'(pass_loop), 32'd1);
        tick();
        tick();
        check("loop idle busy", 32'(busy_loop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
